// File: rtl/matrix_result_collector.sv
// ---------------------------------------------------------------------------
// MatrixResultCollector
//
// Purpose:
//    Takes one wide result bus from the matrix multiplier, captures it under a
//    four-phase in_ready/in_ack handshake, and replays it one word at a time
//    on a valid/ready stream. Word 0 is sent first. A frame is NUM_WORDS words
//    from a single in_ready assertion.
//
// Ports:
//    clk         in   single clock, all logic on the rising edge
//    rst         in   synchronous active-low reset
//    In          in   NUM_WORDS*WORD_W result bus; word k = In[WORD_W*k +: WORD_W]
//    in_ready    in   In is valid while high
//    in_ack      out  four-phase acknowledge back to the multiplier
//    word_out    out  serialized result word (0 whenever word_valid is low)
//    word_valid  out  word_out is valid
//    word_ready  in   downstream accepts word_out on valid & ready
//    frame_done  out  high in the cycle the last word of a frame is accepted
//    nan_seen    out  sticky NaN flag
//
// Configuration:
//    RESULT_NAN_CHECK_EN  when defined, nan_seen sets on acceptance of any
//                         IEEE-754 single NaN word and holds until reset.
//                         When undefined, nan_seen is tied to 0.
// ---------------------------------------------------------------------------
module matrix_result_collector #(
   parameter int NUM_WORDS = 4,
   parameter int WORD_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_WORDS*WORD_W-1:0] In,
   input  logic                        in_ready,
   output logic                        in_ack,
   output logic [WORD_W-1:0]           word_out,
   output logic                        word_valid,
   input  logic                        word_ready,
   output logic                        frame_done,
   output logic                        nan_seen
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] wordIdx_q, wordIdx_d;
   logic             inAck_q, inAck_d;
   logic [WORD_W-1:0] buffer_q [NUM_WORDS];

   logic capture;
   logic wordAccept;
   logic lastAccept;

   // A new frame is only taken in IDLE with the previous handshake fully
   // closed, so a still-high in_ready from the last frame never re-captures.
   assign capture    = (state_q == IDLE) && in_ready && !inAck_q;
   assign wordAccept = (state_q == SEND) && word_ready;
   assign lastAccept = wordAccept && (wordIdx_q == LAST_IDX);

   assign in_ack     = inAck_q;
   assign word_valid = (state_q == SEND);
   assign word_out   = (state_q == SEND) ? buffer_q[wordIdx_q] : '0;
   assign frame_done = lastAccept;

   // Next-state logic. The acknowledge follows the multiplier's in_ready
   // independently of the streaming side: it falls as soon as in_ready is
   // seen low, even mid-frame, without aborting the words already buffered.
   // At the end of a frame we wait in HOLD only while the handshake is still
   // open, so IDLE always means "free to capture".
   always_comb begin
      state_d   = state_q;
      wordIdx_d = wordIdx_q;
      inAck_d   = inAck_q;

      if (!in_ready) begin
         inAck_d = 1'b0;
      end else if (capture) begin
         inAck_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (capture) begin
               state_d   = SEND;
               wordIdx_d = '0;
            end
         end
         SEND: begin
            if (wordAccept) begin
               if (wordIdx_q == LAST_IDX) begin
                  wordIdx_d = '0;
                  state_d   = inAck_d ? HOLD : IDLE;
               end else begin
                  wordIdx_d = wordIdx_q + IDX_W'(1);
               end
            end
         end
         HOLD: begin
            if (!inAck_d) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers; reset drops any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         wordIdx_q <= '0;
         inAck_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wordIdx_q <= wordIdx_d;
         inAck_q   <= inAck_d;
      end
   end

   // Frame buffer. It is loaded only on capture, so later activity on In
   // cannot disturb a frame being drained. No reset is needed because
   // word_out is forced to 0 outside SEND.
   always_ff @(posedge clk) begin
      if (rst && capture) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            buffer_q[k] <= In[WORD_W*k +: WORD_W];
         end
      end
   end

`ifdef RESULT_NAN_CHECK_EN
   logic nanSeen_q;
   logic wordIsNan;

   // NaN means exponent all ones with a nonzero mantissa; infinity
   // (mantissa zero) deliberately does not count.
   assign wordIsNan = (&word_out[30:23]) && (|word_out[22:0]);

   // Sticky until reset; only words actually accepted downstream count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         nanSeen_q <= 1'b0;
      end else if (wordAccept && wordIsNan) begin
         nanSeen_q <= 1'b1;
      end
   end

   assign nan_seen = nanSeen_q;
`else
   assign nan_seen = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_result_collector.sv
// ---------------------------------------------------------------------------
// TbMatrixResultCollector
//
// Bench for matrix_result_collector. A transaction-level reference keeps the
// buffered frame as a queue of words still owed downstream plus the state of
// the acknowledge and the sticky NaN flag; every cycle the DUT outputs are
// compared with what that queue implies. Directed frames cover the worked
// examples, then a randomized phase exercises handshake, stalls and resets.
// ---------------------------------------------------------------------------
module tb_matrix_result_collector;

   localparam int NW  = 4;
   localparam int WW  = 32;
   localparam int BUS = NW * WW;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [BUS-1:0] In = '0;
   logic           in_ready = 1'b0;
   logic           in_ack;
   logic [WW-1:0]  word_out;
   logic           word_valid;
   logic           word_ready = 1'b0;
   logic           frame_done;
   logic           nan_seen;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mQ[$];
   bit          mAck        = 1'b0;
   bit          mNan        = 1'b0;
   bit          mAfterReset = 1'b1;

   matrix_result_collector #(
      .NUM_WORDS (NW),
      .WORD_W    (WW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .In         (In),
      .in_ready   (in_ready),
      .in_ack     (in_ack),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_done (frame_done),
      .nan_seen   (nan_seen)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   function automatic logic [BUS-1:0] mkBus(input logic [31:0] w3, input logic [31:0] w2,
                                            input logic [31:0] w1, input logic [31:0] w0);
      return {w3, w2, w1, w0};
   endfunction

   function automatic bit isNan(input logic [31:0] w);
      return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
   endfunction

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, observed, expected);
      end
   endtask

   // Drives one cycle of inputs on the falling edge, checks the DUT against
   // the reference, then advances the reference across the next rising edge.
   task automatic applyStimulus(input bit r, input bit ir, input logic [BUS-1:0] bus, input bit wr);
      bit expValid;
      logic [31:0] w;
      @(negedge clk);
      rst        = r;
      in_ready   = ir;
      In         = bus;
      word_ready = wr;
      #1;
      expValid = (mQ.size() != 0);
      checkOutput("word_valid", 32'(word_valid), 32'(expValid));
      checkOutput("in_ack", 32'(in_ack), 32'(mAck));
      if (expValid) begin
         checkOutput("word_out", word_out, mQ[0]);
      end else if (mAfterReset) begin
         checkOutput("word_out_rst", word_out, 32'd0);
      end
      checkOutput("frame_done", 32'(frame_done), 32'(expValid && wr && (mQ.size() == 1)));
      checkOutput("nan_seen", 32'(nan_seen), 32'(mNan));

      if (!r) begin
         mQ.delete();
         mAck        = 1'b0;
         mNan        = 1'b0;
         mAfterReset = 1'b1;
      end else begin
         bit captured = 1'b0;
         mAfterReset = 1'b0;
         if (expValid && wr) begin
            w = mQ.pop_front();
`ifdef RESULT_NAN_CHECK_EN
            if (isNan(w)) mNan = 1'b1;
`endif
         end else if (!expValid && !mAck && ir) begin
            for (int k = 0; k < NW; k++) mQ.push_back(bus[WW*k +: WW]);
            captured = 1'b1;
         end
         if (!ir) mAck = 1'b0;
         else if (captured) mAck = 1'b1;
      end
   endtask

   task automatic runCycles(input int n, input bit r, input bit ir,
                            input logic [BUS-1:0] bus, input bit wr);
      for (int i = 0; i < n; i++) applyStimulus(r, ir, bus, wr);
   endtask

   logic [BUS-1:0] frameA;
   logic [BUS-1:0] frameB;

   initial begin
      frameA = mkBus(32'h41B00000, 32'h41700000, 32'h41200000, 32'h40E00000);
      frameB = mkBus(32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000);

      // Reset, then idle with in_ready low: nothing must move.
      runCycles(2, 1'b0, 1'b0, '0, 1'b0);
      runCycles(6, 1'b1, 1'b0, frameA, 1'b1);

      // Full-rate frame, then close the handshake.
      runCycles(6, 1'b1, 1'b1, frameA, 1'b1);
      runCycles(2, 1'b1, 1'b0, '0, 1'b1);

      // Same frame with downstream stalls 1,0,0,1,...
      applyStimulus(1'b1, 1'b1, frameA, 1'b0);
      for (int i = 0; i < 12; i++) begin
         bit wr = (i % 3 == 0);
         applyStimulus(1'b1, 1'b1, frameA, wr);
      end
      runCycles(2, 1'b1, 1'b0, '0, 1'b0);

      // in_ready held 10 cycles with In cleared after capture: no recapture.
      applyStimulus(1'b1, 1'b1, frameA, 1'b1);
      runCycles(10, 1'b1, 1'b1, '0, 1'b1);
      runCycles(2, 1'b1, 1'b0, '0, 1'b1);

      // Reset after two words, then a fresh frame from word 0.
      applyStimulus(1'b1, 1'b1, frameA, 1'b1);
      runCycles(2, 1'b1, 1'b1, frameA, 1'b1);
      applyStimulus(1'b0, 1'b0, frameA, 1'b1);
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      runCycles(6, 1'b1, 1'b1, frameB, 1'b1);
      runCycles(2, 1'b1, 1'b0, '0, 1'b1);

      // NaN in word 2 sets the sticky flag; in_ready dropped mid-frame.
      applyStimulus(1'b1, 1'b1, mkBus(32'h3F800000, 32'h7FC00000, 32'h0, 32'h1), 1'b1);
      runCycles(2, 1'b1, 1'b0, '0, 1'b1);
      runCycles(4, 1'b1, 1'b0, '0, 1'b1);
      runCycles(2, 1'b0, 1'b0, '0, 1'b0);
      // Infinity in word 2 must not set it.
      applyStimulus(1'b1, 1'b1, mkBus(32'h3F800000, 32'h7F800000, 32'h0, 32'h1), 1'b1);
      runCycles(5, 1'b1, 1'b0, '0, 1'b1);

      // Randomized phase.
      begin
         bit ir = 1'b0;
         for (int c = 0; c < 600; c++) begin
            logic [BUS-1:0] bus;
            bit r;
            bit wr;
            if ($urandom_range(0, 3) == 0) ir = !ir;
            for (int k = 0; k < NW; k++) begin
               logic [31:0] w;
               int sel;
               w   = $urandom;
               sel = int'($urandom_range(0, 9));
               if (sel == 0) w = 32'h7FC00000 | ($urandom & 32'h003FFFFF);
               if (sel == 1) w = 32'h7F800000;
               bus[WW*k +: WW] = w;
            end
            r  = ($urandom_range(0, 79) != 0);
            wr = ($urandom_range(0, 1) != 0);
            applyStimulus(r, ir, bus, wr);
         end
      end
      runCycles(8, 1'b1, 1'b0, '0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matrix_result_collector.md
MATRIX_RESULT_COLLECTOR -- requirements
Module: matrix_result_collector

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 4, meaning the number of 32-bit IEEE-754 single words per result bus.
REQ-002 SHALL have parameter WORD_W, default 32, meaning the width of one word; the bus width is NUM_WORDS*WORD_W.
REQ-003 clk  input  1  the single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low (rst=0 resets on a rising clk edge).
REQ-005 In  input  NUM_WORDS*WORD_W  result bus from matrix_multiplier Out; word k = In[WORD_W*k+WORD_W-1 : WORD_W*k].
REQ-006 in_ready  input  1  matrix_multiplier out_ready; In is valid while high.
REQ-007 in_ack  output  1  drives matrix_multiplier out_ack; four-phase acknowledge.
REQ-008 word_out  output  WORD_W  serialized result word.
REQ-009 word_valid  output  1  word_out is valid.
REQ-010 word_ready  input  1  downstream accepts word_out when word_valid & word_ready at a rising edge.
REQ-011 frame_done  output  1  one-cycle pulse when the last word of a frame is accepted.
REQ-012 nan_seen  output  1  sticky NaN flag (only with RESULT_NAN_CHECK_EN; else tied 0).

Function
REQ-013 SHALL implement states IDLE, SEND, HOLD; one frame = NUM_WORDS words captured from one in_ready assertion.
REQ-014 IDLE: if in_ready=1 and in_ack=0, SHALL capture In into an internal buffer, set in_ack=1, clear word index to 0, enter SEND on the same edge.
REQ-015 in_ack SHALL stay high until in_ready is sampled low, then drop on that edge, in any state; in IDLE no new capture while in_ack=1.
REQ-016 SEND: word_valid=1, word_out = buffer word[index]; on word_valid & word_ready index increments; word_out SHALL be stable while word_valid=1 and word_ready=0.
REQ-017 Acceptance of word NUM_WORDS-1 SHALL pulse frame_done for exactly that cycle, deassert word_valid next cycle, and go to IDLE if in_ack falls on that edge or is already 0, else HOLD.
REQ-018 HOLD: word_valid=0; SHALL return to IDLE on the edge in_ack drops.
REQ-019 Latency: in_ready sampled high at edge t in IDLE -> in_ack and word_valid high after edge t; word 0 accepted no earlier than edge t+1; with word_ready held 1 a frame drains in NUM_WORDS cycles.
REQ-020 Changes on In after capture SHALL NOT affect the buffered frame.
REQ-021 word_ready while word_valid=0 SHALL be ignored; index never exceeds NUM_WORDS-1 (no wrap into a stale word).
REQ-022 in_ready dropping mid-SEND SHALL drop in_ack but SHALL NOT abort the frame.

Reset
REQ-023 rst=0 at a rising edge SHALL force IDLE, in_ack=0, word_valid=0, frame_done=0, index=0, word_out=0, nan_seen=0, regardless of state.
REQ-024 Reset mid-frame SHALL discard remaining words; the next frame requires a fresh in_ready rising with in_ack=0.

Configuration
REQ-025 Macro RESULT_NAN_CHECK_EN defined: nan_seen SHALL set on acceptance of any word with exponent bits all 1 and mantissa nonzero, and hold until reset.
REQ-026 Macro not defined: no NaN logic synthesized; nan_seen SHALL be constant 0; all other behaviour identical.

Verification
REQ-027 In={0x41B00000,0x41700000,0x41200000,0x40E00000} (k3..k0), in_ready=1, word_ready=1 -> words 0x40E00000, 0x41200000, 0x41700000, 0x41B00000 on 4 consecutive cycles, frame_done on the 4th.
REQ-028 Same frame, word_ready toggling 1,0,0,1,... -> word_out held stable during stalls, 4 words in order, no duplicates or drops.
REQ-029 in_ready held high 10 cycles after capture, In changed to all zero -> in_ack stays 1 until in_ready low, original 4 words delivered, no second capture, FSM passes through HOLD.
REQ-030 rst=0 after second word accepted -> next edge word_valid=0, in_ack=0, IDLE; new frame 1.0,2.0,3.0,4.0 (0x3F800000..0x40800000) then delivered from word 0.
REQ-031 With RESULT_NAN_CHECK_EN, word 2 = 0x7FC00000 -> nan_seen=1 from its acceptance until reset; word 2 = 0x7F800000 (infinity) -> nan_seen stays 0.
REQ-032 in_ready low throughout -> in_ack, word_valid, frame_done stay 0 indefinitely.
